// File: rtl/seg7_pkg.sv
// Shared 7-segment pattern constants (active-low, bit 0 = segment a) and decode result type.
// Used by both the display driver and the scan reader.
package seg7_pkg;

    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0000100;
    localparam logic [0:6] SEG_A     = 7'b0001000;
    localparam logic [0:6] SEG_B     = 7'b1100000;
    localparam logic [0:6] SEG_C     = 7'b0110001;
    localparam logic [0:6] SEG_D     = 7'b1000010;
    localparam logic [0:6] SEG_E     = 7'b0110000;
    localparam logic [0:6] SEG_F     = 7'b0111000;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    // Entry i is the pattern that displays hex value i.
    localparam logic [0:6] SEG_TABLE [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
    };

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] nibble;
    } seg_dec_t;

    // True when more than one bit is set.
    function automatic logic multi_hot(input logic [31:0] v);
        return |(v & (v - 32'd1));
    endfunction

endpackage

// File: rtl/seg7_scan_reader_if.sv
// Display-bus sample inputs and decoded readback outputs of the scan reader.
// master = whoever drives the display bus; slave = the reader itself.
interface seg7_scan_reader_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [0:6]              seg_in;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic                    err_clr;
    logic [4*NUM_DIGITS-1:0] digits_out;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    upd;
    logic [IDX_W-1:0]        upd_idx;
    logic                    err;

    modport master (
        output seg_in, dig_sel, err_clr,
        input  digits_out, digit_valid, upd, upd_idx, err
    );

    modport slave (
        input  seg_in, dig_sel, err_clr,
        output digits_out, digit_valid, upd, upd_idx, err
    );

endinterface

// File: rtl/seg7_pattern_decoder.sv
// Combinational inverse of the hex-to-7-segment table.
// Blank is reported separately and is not legal; anything else unknown is illegal.
module seg7_pattern_decoder
    import seg7_pkg::*;
(
    input  logic [0:6] seg,
    output seg_dec_t   dec
);

    always_comb begin
        dec = '0;
        dec.blank = (seg == SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_TABLE[i]) begin
                dec.legal  = 1'b1;
                dec.nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Samples the multiplexed display bus, waits for a stable {dig_sel, seg} pair and
// stores the decoded value of the strobed digit, with update pulse and sticky error.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input logic              clk,
    input logic              rst_n,
    seg7_scan_reader_if.slave bus
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYCLES - 1);

    logic [NUM_DIGITS-1:0]   dig_q;
    logic [0:6]              seg_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic                    upd_q, upd_d;
    logic [IDX_W-1:0]        upd_idx_q, upd_idx_d;
    logic                    err_q, err_d;

    logic                    changed;
    logic                    accept;
    logic                    any_hot;
    logic                    multi;
    logic [IDX_W-1:0]        hot_idx;
    logic [3:0]              cur_val;
    logic                    cur_valid;
    seg_dec_t                dec;

    seg7_pattern_decoder u_decoder (
        .seg (seg_q),
        .dec (dec)
    );

    // Compares the incoming sample with the registered one, i.e. new in_q vs. old in_q.
    assign changed = (bus.dig_sel != dig_q) || (bus.seg_in != seg_q);
    assign accept  = !changed && (cnt_q == CNT_ACC);

    assign any_hot = |dig_q;
    assign multi   = multi_hot(32'(dig_q));

    always_comb begin
        hot_idx = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (dig_q[i]) begin
                hot_idx = IDX_W'(i);
            end
        end
    end

    assign cur_val   = digits_q[{hot_idx, 2'b00} +: 4];
    assign cur_valid = valid_q[hot_idx];

    always_comb begin
        if (changed) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        logic err_set;
        err_set   = 1'b0;
        digits_d  = digits_q;
        valid_d   = valid_q;
        upd_d     = 1'b0;
        upd_idx_d = upd_idx_q;

        if (accept && any_hot) begin
            if (multi) begin
                err_set = 1'b1;
            end else if (dec.blank) begin
                valid_d[hot_idx] = 1'b0;
                upd_d            = cur_valid;
            end else if (dec.legal) begin
                digits_d[{hot_idx, 2'b00} +: 4] = dec.nibble;
                valid_d[hot_idx]                = 1'b1;
                upd_d = !cur_valid || (cur_val != dec.nibble);
            end else begin
                err_set          = 1'b1;
                valid_d[hot_idx] = 1'b0;
                upd_d            = cur_valid;
            end
            if (upd_d) begin
                upd_idx_d = hot_idx;
            end
        end

        // A new error wins over a simultaneous clear.
        if (err_set) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q     <= '0;
            seg_q     <= '0;
            cnt_q     <= '0;
            digits_q  <= '0;
            valid_q   <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
            err_q     <= 1'b0;
        end else begin
            dig_q     <= bus.dig_sel;
            seg_q     <= bus.seg_in;
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
            err_q     <= err_d;
        end
    end

    assign bus.digits_out  = digits_q;
    assign bus.digit_valid = valid_q;
    assign bus.upd         = upd_q;
    assign bus.upd_idx     = upd_idx_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Randomized and directed bench for seg7_scan_reader against a run-length based reference model.
module tb_seg7_scan_reader;

    localparam int N  = 4;
    localparam int SC = 4;

    localparam logic [6:0] PAT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    localparam logic [6:0] BLANK = 7'b1111111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seg7_scan_reader_if #(.NUM_DIGITS(N)) bus ();

    seg7_scan_reader #(
        .NUM_DIGITS    (N),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: a pair is accepted when it has been seen on SC+1 consecutive edges.
    logic [3:0] last_d;
    logic [6:0] last_s;
    int         run_len;
    int         m_dig [N];
    bit         m_valid [N];
    bit         m_upd;
    int         m_idx;
    bit         m_err;

    task automatic model_reset();
        last_d  = '0;
        last_s  = '0;
        run_len = 1;
        for (int i = 0; i < N; i++) begin
            m_dig[i]   = 0;
            m_valid[i] = 0;
        end
        m_upd = 0;
        m_idx = 0;
        m_err = 0;
    endtask

    task automatic model_edge(input logic [3:0] d, input logic [6:0] s, input logic clr);
        bit set_err;
        int idx;
        int code;
        set_err = 0;
        m_upd   = 0;
        if (d == last_d && s == last_s) begin
            run_len++;
        end else begin
            run_len = 1;
            last_d  = d;
            last_s  = s;
        end
        if (run_len == SC + 1 && d != 0) begin
            if ($countones(d) > 1) begin
                set_err = 1;
            end else begin
                idx  = $clog2(int'(d));
                code = -1;
                for (int k = 0; k < 16; k++) if (s == PAT[k]) code = k;
                if (s == BLANK) begin
                    m_upd        = m_valid[idx];
                    m_valid[idx] = 0;
                end else if (code >= 0) begin
                    m_upd        = !m_valid[idx] || m_dig[idx] != code;
                    m_dig[idx]   = code;
                    m_valid[idx] = 1;
                end else begin
                    set_err      = 1;
                    m_upd        = m_valid[idx];
                    m_valid[idx] = 0;
                end
                if (m_upd) m_idx = idx;
            end
        end
        if (set_err) m_err = 1;
        else if (clr) m_err = 0;
    endtask

    task automatic compare_all();
        logic [15:0] ed;
        logic [3:0]  ev;
        for (int i = 0; i < N; i++) begin
            ed[4*i +: 4] = 4'(m_dig[i]);
            ev[i]        = m_valid[i];
        end
        check("digits_out", 32'(bus.digits_out), 32'(ed));
        check("digit_valid", 32'(bus.digit_valid), 32'(ev));
        check("upd", 32'(bus.upd), 32'(m_upd));
        check("err", 32'(bus.err), 32'(m_err));
        if (m_upd) check("upd_idx", 32'(bus.upd_idx), 32'(m_idx));
    endtask

    // Drive at negedge, let one posedge happen, step the model, compare at the next negedge.
    task automatic cycle(input logic [3:0] d, input logic [6:0] s, input logic clr);
        bus.dig_sel = d;
        bus.seg_in  = s;
        bus.err_clr = clr;
        @(posedge clk);
        model_edge(d, s, clr);
        @(negedge clk);
        compare_all();
    endtask

    task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) cycle(d, s, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst_digits", 32'(bus.digits_out), 32'h0);
        check("rst_valid", 32'(bus.digit_valid), 32'h0);
        check("rst_upd", 32'(bus.upd), 32'h0);
        check("rst_upd_idx", 32'(bus.upd_idx), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #2;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [3:0] d;
        logic [6:0] s;
        int         n;

        bus.dig_sel = '0;
        bus.seg_in  = '0;
        bus.err_clr = 1'b0;
        model_reset();
        #1;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Digit 0 shows 3.
        hold(4'b0001, PAT[3], SC + 1);
        check("t1_digit0", 32'(bus.digits_out[3:0]), 32'h3);
        check("t1_upd", 32'(bus.upd), 32'h1);
        hold(4'b0000, BLANK, 2);

        // Too short a hold on digit 2, then a proper one showing A.
        hold(4'b0100, PAT[10], SC - 1);
        hold(4'b0000, BLANK, 2);
        hold(4'b0100, PAT[10], SC + 2);
        check("t2_digit2", 32'(bus.digits_out[11:8]), 32'hA);

        // Same value after an idle gap is silent; blanking drops valid with a pulse.
        hold(4'b0000, BLANK, 3);
        hold(4'b0100, PAT[10], SC + 2);
        hold(4'b0100, BLANK, SC + 2);
        check("t3_valid2", 32'(bus.digit_valid[2]), 32'h0);

        // Illegal pattern on digit 1; clear racing a new error, then clear alone.
        hold(4'b0010, 7'b1111110, SC + 2);
        check("t4_err", 32'(bus.err), 32'h1);
        hold(4'b0010, 7'b1111101, SC);
        cycle(4'b0010, 7'b1111101, 1'b1);
        check("t4_err_race", 32'(bus.err), 32'h1);
        cycle(4'b0010, 7'b1111101, 1'b1);
        check("t4_err_clr", 32'(bus.err), 32'h0);

        // Multi-hot select, then reset in the middle of a run.
        hold(4'b0011, PAT[1], SC + 2);
        check("t5_err", 32'(bus.err), 32'h1);
        hold(4'b0001, PAT[7], 2);
        reset_pulse();
        hold(4'b0001, PAT[7], 3);
        hold(4'b0000, BLANK, SC + 2);

        // Round-robin scan of 1,2,3,4.
        for (int k = 0; k < N; k++) hold(4'(1 << k), PAT[k + 1], SC + 1);
        check("t6_digits", 32'(bus.digits_out), 32'h4321);
        check("t6_valid", 32'(bus.digit_valid), 32'hF);

        // Random traffic.
        for (int it = 0; it < 200; it++) begin
            case ($urandom_range(0, 9))
                0: d = 4'b0000;
                1: begin
                    d = 4'($urandom_range(0, 15));
                    while ($countones(d) < 2) d = 4'($urandom_range(0, 15));
                end
                default: d = 4'(1 << $urandom_range(0, N - 1));
            endcase
            case ($urandom_range(0, 9))
                0: s = BLANK;
                1: s = 7'($urandom_range(0, 127));
                default: s = PAT[$urandom_range(0, 15)];
            endcase
            n = $urandom_range(1, 8);
            for (int c = 0; c < n; c++) cycle(d, s, 1'($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 39) == 0) reset_pulse();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
